// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, default widths and the arbiter FSM encoding.
package alu_pkg;
   localparam int ALU_OP_W = 3;
   localparam int XLEN_DEF = 32;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // High for op codes 3'b101..3'b111, for which the ALU outputs 0.
   function automatic logic op_illegal(input logic [ALU_OP_W-1:0] op);
      return op > ALU_SLT;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request after last_grant, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);
   logic             found;
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      sum     = '0;
      cand    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         // last_grant + k never exceeds 2*NUM_REQ-1, so one subtraction wraps it.
         sum = {1'b0, last_grant} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_REQ))
            sum = sum - (IDX_W+1)'(NUM_REQ);
         cand = sum[IDX_W-1:0];
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one single-cycle ALU among NUM_REQ requesters, one op in flight.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = XLEN_DEF,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*XLEN-1:0]     req_a,
   input  logic [NUM_REQ*XLEN-1:0]     req_b,
   input  logic [NUM_REQ*ALU_OP_W-1:0] req_op,
   output logic [XLEN-1:0]             alu_src_a,
   output logic [XLEN-1:0]             alu_src_b,
   output logic [ALU_OP_W-1:0]         alu_ctrl,
   input  logic [XLEN-1:0]             alu_result,
   input  logic                        alu_zero,
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [XLEN-1:0]             rsp_result,
   output logic                        rsp_zero,
   output logic                        rsp_illegal,
   output logic                        busy
);
   state_t                            state;
   logic [IDX_W-1:0]                  last_grant;
   logic [IDX_W-1:0]                  owner;
   logic [XLEN-1:0]                   opa_q;
   logic [XLEN-1:0]                   opb_q;
   logic [ALU_OP_W-1:0]               opc_q;

   logic [NUM_REQ-1:0][XLEN-1:0]      a_arr;
   logic [NUM_REQ-1:0][XLEN-1:0]      b_arr;
   logic [NUM_REQ-1:0][ALU_OP_W-1:0]  op_arr;
   logic [NUM_REQ-1:0]                gnt;
   logic [IDX_W-1:0]                  gnt_idx;
   logic                              accept;

   assign a_arr  = req_a;
   assign b_arr  = req_b;
   assign op_arr = req_op;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .gnt        (gnt),
      .gnt_idx    (gnt_idx)
   );

   // The arbiter only resolves while idle; requests arriving mid-operation just wait.
   assign req_ready = (state == ST_IDLE) ? gnt : '0;
   assign accept    = (state == ST_IDLE) && (|gnt);

   // ALU is driven straight from the operand registers so it sees stable inputs all of EXEC.
   assign alu_src_a = opa_q;
   assign alu_src_b = opb_q;
   assign alu_ctrl  = opc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         last_grant  <= IDX_W'(NUM_REQ-1);
         owner       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         opc_q       <= '0;
         rsp_valid   <= '0;
         rsp_result  <= '0;
         rsp_zero    <= 1'b0;
         rsp_illegal <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  opa_q      <= a_arr[gnt_idx];
                  opb_q      <= b_arr[gnt_idx];
                  opc_q      <= op_arr[gnt_idx];
                  owner      <= gnt_idx;
                  last_grant <= gnt_idx;
                  busy       <= 1'b1;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_result  <= alu_result;
               rsp_zero    <= alu_zero;
               rsp_illegal <= op_illegal(opc_q);
               rsp_valid   <= NUM_REQ'(1) << owner;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready[owner]) begin
                  rsp_valid <= '0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid <= '0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU on the alu_* pins.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   localparam int NR = 2;
   localparam int XL = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NR*XL-1:0]  req_a, req_b;
   logic [NR*3-1:0]   req_op;
   logic [XL-1:0]     alu_src_a, alu_src_b, alu_result, rsp_result;
   logic [2:0]        alu_ctrl;
   logic              alu_zero, rsp_zero, rsp_illegal, busy;

   always #5 clk = ~clk;

   alu_share_arbiter #(.NUM_REQ(NR), .XLEN(XL)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
      .busy(busy)
   );

   function automatic logic [XL-1:0] alu_f(input logic [XL-1:0] a, input logic [XL-1:0] b,
                                           input logic [2:0] op);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_SLT: return ($signed(a) < $signed(b)) ? XL'(1) : '0;
         default: return '0;
      endcase
   endfunction

   assign alu_result = alu_f(alu_src_a, alu_src_b, alu_ctrl);
   assign alu_zero   = (alu_result == '0);

   typedef struct { int idx; logic [XL-1:0] a; logic [XL-1:0] b; logic [2:0] op; } job_t;
   typedef struct { int idx; logic [XL-1:0] res; logic zero; logic ill; } rsp_t;

   job_t      jq0[$], jq1[$];
   rsp_t      exp_q[$], rsp_log[$];
   int        glog[$];
   logic [NR-1:0] acc = '0;
   logic [NR-1:0] rdy = '0;
   int        npass = 0;
   int        ntot  = 0;

   // Requester model: present the head job of each queue, retire it once accepted.
   always @(posedge clk) begin
      #1;
      if (acc[0] && jq0.size() > 0) void'(jq0.pop_front());
      if (acc[1] && jq1.size() > 0) void'(jq1.pop_front());
      req_valid[0] = (jq0.size() > 0);
      req_valid[1] = (jq1.size() > 0);
      if (jq0.size() > 0) begin
         req_a[0 +: XL] = jq0[0].a; req_b[0 +: XL] = jq0[0].b; req_op[0 +: 3] = jq0[0].op;
      end
      if (jq1.size() > 0) begin
         req_a[XL +: XL] = jq1[0].a; req_b[XL +: XL] = jq1[0].b; req_op[3 +: 3] = jq1[0].op;
      end
      rsp_ready = rdy;
   end

   // Monitor: scoreboard compare on each response handshake, record grants and expectations.
   always @(negedge clk) begin
      rsp_t e;
      job_t j;
      int   ri;
      acc = req_valid & req_ready;
      if (rst_n) begin
         ntot++;
         if ($countones(rsp_valid) > 1 || $countones(req_ready) > 1)
            $display("FAIL onehot rsp_valid=%b req_ready=%b required at most one bit", rsp_valid, req_ready);
         else npass++;
         if ((rsp_valid & rsp_ready) != '0) begin
            ri = rsp_valid[0] ? 0 : 1;
            ntot++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected rsp idx=%0d result=%h with no expectation", ri, rsp_result);
            end else begin
               e = exp_q.pop_front();
               if (ri !== e.idx || rsp_result !== e.res || rsp_zero !== e.zero || rsp_illegal !== e.ill)
                  $display("FAIL sb_rsp got idx=%0d res=%h z=%b ill=%b required idx=%0d res=%h z=%b ill=%b",
                           ri, rsp_result, rsp_zero, rsp_illegal, e.idx, e.res, e.zero, e.ill);
               else npass++;
            end
            rsp_log.push_back('{ri, rsp_result, rsp_zero, rsp_illegal});
         end
         for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
               j = (i == 0) ? jq0[0] : jq1[0];
               glog.push_back(i);
               e.idx  = i;
               e.res  = alu_f(j.a, j.b, j.op);
               e.zero = (e.res == '0);
               e.ill  = (j.op > 3'b100);
               exp_q.push_back(e);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push_job(input int idx, input logic [XL-1:0] a, input logic [XL-1:0] b,
                           input logic [2:0] op);
      job_t j;
      j = '{idx, a, b, op};
      if (idx == 0) jq0.push_back(j); else jq1.push_back(j);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      jq0.delete(); jq1.delete(); exp_q.delete();
      step(3);
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic drain(input string name);
      bit done;
      done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk); #1;
         if (jq0.size() == 0 && jq1.size() == 0 && exp_q.size() == 0 && !busy && rsp_valid == '0)
            done = 1;
      end
      ntot++;
      if (!done) $display("FAIL %s_timeout busy=%b pending=%0d required drained", name, busy, exp_q.size());
      else npass++;
      step(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rdy = '0;
      req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
      step(3);
      ntot++;
      if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0)
         $display("FAIL reset_ctrl req_ready=%b rsp_valid=%b busy=%b required 0", req_ready, rsp_valid, busy);
      else npass++;
      ntot++;
      if (rsp_result !== '0 || rsp_zero !== 1'b0 || rsp_illegal !== 1'b0 ||
          alu_src_a !== '0 || alu_src_b !== '0 || alu_ctrl !== '0)
         $display("FAIL reset_data res=%h z=%b ill=%b a=%h b=%h ctrl=%b required 0",
                  rsp_result, rsp_zero, rsp_illegal, alu_src_a, alu_src_b, alu_ctrl);
      else npass++;
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_single_add();
      bit seen;
      rdy = 2'b11; glog.delete(); rsp_log.delete();
      push_job(0, 5, 7, ALU_ADD);
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (req_ready[0]) seen = 1;
      end
      ntot++;
      if (!seen) $display("FAIL add_grant req_ready=%b required 01", req_ready); else npass++;
      @(negedge clk);
      ntot++;
      if (rsp_valid !== 2'b00 || busy !== 1'b1)
         $display("FAIL add_exec rsp_valid=%b busy=%b required 00 1", rsp_valid, busy);
      else npass++;
      @(negedge clk);
      ntot++;
      if (rsp_valid !== 2'b01 || rsp_result !== 32'd12 || rsp_zero !== 1'b0)
         $display("FAIL add_latency rsp_valid=%b res=%0d z=%b required 01 12 0", rsp_valid, rsp_result, rsp_zero);
      else npass++;
      drain("add");
   endtask

   task automatic test_contention();
      apply_reset();
      rdy = 2'b11; glog.delete(); rsp_log.delete();
      push_job(0, 3, 3, ALU_SUB);
      push_job(1, 32'hF0, 32'h0F, ALU_OR);
      drain("cont");
      ntot++;
      if (glog.size() != 2 || rsp_log.size() != 2)
         $display("FAIL cont_count grants=%0d rsps=%0d required 2 2", glog.size(), rsp_log.size());
      else if (glog[0] != 0 || glog[1] != 1 || rsp_log[0].res !== '0 || rsp_log[0].zero !== 1'b1 ||
               rsp_log[1].res !== 32'hFF)
         $display("FAIL cont_order grants=%0d,%0d res0=%h z0=%b res1=%h required 0,1 0 1 ff",
                  glog[0], glog[1], rsp_log[0].res, rsp_log[0].zero, rsp_log[1].res);
      else npass++;
   endtask

   task automatic test_backpressure();
      bit seen;
      rdy = 2'b10; glog.delete(); rsp_log.delete();
      push_job(0, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (rsp_valid[0]) seen = 1;
      end
      ntot++;
      if (!seen) $display("FAIL bp_rsp rsp_valid=%b required 01", rsp_valid); else npass++;
      step(1);
      push_job(1, 1, 2, ALU_ADD);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         ntot++;
         if (rsp_valid !== 2'b01 || rsp_result !== 32'd1 || busy !== 1'b1 || req_ready !== 2'b00)
            $display("FAIL bp_hold cyc=%0d rsp_valid=%b res=%h busy=%b req_ready=%b required 01 1 1 00",
                     c, rsp_valid, rsp_result, busy, req_ready);
         else npass++;
      end
      step(1);
      rdy = 2'b11;
      drain("bp");
      ntot++;
      if (glog.size() != 2 || rsp_log.size() != 2)
         $display("FAIL bp_count grants=%0d rsps=%0d required 2 2", glog.size(), rsp_log.size());
      else if (glog[0] != 0 || glog[1] != 1 || rsp_log[0].res !== 32'd1 || rsp_log[1].res !== 32'd3)
         $display("FAIL bp_order grants=%0d,%0d res=%h,%h required 0,1 1,3",
                  glog[0], glog[1], rsp_log[0].res, rsp_log[1].res);
      else npass++;
   endtask

   task automatic test_illegal();
      rdy = 2'b11; glog.delete(); rsp_log.delete();
      push_job(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111);
      drain("ill");
      ntot++;
      if (rsp_log.size() != 1)
         $display("FAIL ill_count rsps=%0d required 1", rsp_log.size());
      else if (rsp_log[0].idx != 1 || rsp_log[0].res !== '0 || rsp_log[0].zero !== 1'b1 ||
               rsp_log[0].ill !== 1'b1)
         $display("FAIL ill_rsp idx=%0d res=%h z=%b ill=%b required 1 0 1 1",
                  rsp_log[0].idx, rsp_log[0].res, rsp_log[0].zero, rsp_log[0].ill);
      else npass++;
   endtask

   task automatic test_fairness();
      int exp_g[6];
      exp_g = '{0, 1, 0, 1, 0, 1};
      rdy = 2'b11; glog.delete(); rsp_log.delete();
      for (int k = 0; k < 3; k++) begin
         push_job(0, $urandom, $urandom, 3'($urandom_range(0, 4)));
         push_job(1, $urandom, $urandom, 3'($urandom_range(0, 7)));
      end
      drain("fair");
      ntot++;
      if (glog.size() != 6) $display("FAIL fair_count grants=%0d required 6", glog.size());
      else npass++;
      for (int k = 0; k < 6 && k < glog.size(); k++) begin
         ntot++;
         if (glog[k] != exp_g[k]) $display("FAIL fair_grant%0d got=%0d required %0d", k, glog[k], exp_g[k]);
         else npass++;
      end
   endtask

   task automatic test_reset_midop();
      bit seen;
      rdy = 2'b11; glog.delete(); rsp_log.delete();
      push_job(0, 9, 4, ALU_SUB);
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (req_ready[0]) seen = 1;
      end
      step(1);
      rst_n = 1'b0;
      jq0.delete(); jq1.delete(); exp_q.delete();
      #1;
      ntot++;
      if (!seen || rsp_valid !== '0 || busy !== 1'b0 || rsp_result !== '0 || alu_src_a !== '0)
         $display("FAIL rst_async seen=%b rsp_valid=%b busy=%b res=%h a=%h required 1 00 0 0 0",
                  seen, rsp_valid, busy, rsp_result, alu_src_a);
      else npass++;
      step(2);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         ntot++;
         if (rsp_valid !== '0) $display("FAIL rst_norsp rsp_valid=%b required 00", rsp_valid);
         else npass++;
      end
      step(1);
      glog.delete(); rsp_log.delete();
      push_job(1, 2, 2, ALU_AND);
      drain("rst1");
      ntot++;
      if (glog.size() != 1 || glog[0] != 1)
         $display("FAIL rst_solo grants=%0d first=%0d required 1 1", glog.size(),
                  (glog.size() > 0) ? glog[0] : -1);
      else npass++;
      apply_reset();
      glog.delete(); rsp_log.delete();
      push_job(0, 1, 1, ALU_ADD);
      push_job(1, 1, 1, ALU_SUB);
      drain("rst2");
      ntot++;
      if (glog.size() != 2 || glog[0] != 0 || glog[1] != 1)
         $display("FAIL rst_both grants=%0d first=%0d required 2 0", glog.size(),
                  (glog.size() > 0) ? glog[0] : -1);
      else npass++;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_contention();
      test_backpressure();
      test_illegal();
      test_fairness();
      test_reset_midop();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
